// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// TCON bit positions, FSM encoding and the address-map helper.
package timer_pkg;

  localparam logic [4:0] TH_OFS      = 5'h00;
  localparam logic [4:0] TL_OFS      = 5'h04;
  localparam logic [4:0] TCON_OFS    = 5'h08;
  localparam logic [4:0] PRESC_OFS   = 5'h0C;
  localparam logic [4:0] SYSTICK_OFS = 5'h10;

  localparam int TCON_EN      = 0;
  localparam int TCON_IE      = 1;
  localparam int TCON_PEND    = 2;
  localparam int TCON_ONESHOT = 3;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } timer_state_e;

  // True when the word offset inside the 32-byte window holds a register.
  function automatic logic ofsMapped(input logic [4:0] ofs);
    case (ofs)
      TH_OFS, TL_OFS, TCON_OFS, PRESC_OFS: return 1'b1;
`ifdef TIMER_SYSTICK_EN
      SYSTICK_OFS: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a one-cycle tick every (divisor+1) cycles while run
// is high; clear restarts the period from zero.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               clear,
  input  logic [PRESC_W-1:0] divisor,
  output logic               tick
);

  logic [PRESC_W-1:0] count;

  assign tick = run && (count == divisor);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Interval timer and interrupt controller on the core data bus.
// Build option: define TIMER_SYSTICK_EN to map a free-running cycle counter at 0x10.
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iAddr,
  input  logic        iWrite,
  input  logic [31:0] iWData,
  input  logic        iRead,
  output logic [31:0] oRData,
  output logic        oHit,
  output logic        oInterrupt
);

  logic [31:0]        th;
  logic [31:0]        tl;
  logic               ie;
  logic               pend;
  logic               oneShot;
  logic [PRESC_W-1:0] presc;
  timer_state_e       state;
  timer_state_e       stateNext;
  logic               prescClear;
  logic               tick;
  logic               overflow;
  logic [4:0]         ofs;

  // Bus protocol: iWrite commits on the next posedge only when oHit is set;
  // iRead merely qualifies oRData in the same cycle and never changes state.
  assign ofs  = iAddr[4:0];
  assign oHit = (iAddr[31:5] == BASE_ADDR[31:5]) && (iAddr[1:0] == 2'b00) && ofsMapped(ofs);

  logic wrTh, wrTl, wrTcon, wrPresc;
  assign wrTh    = iWrite && oHit && (ofs == TH_OFS);
  assign wrTl    = iWrite && oHit && (ofs == TL_OFS);
  assign wrTcon  = iWrite && oHit && (ofs == TCON_OFS);
  assign wrPresc = iWrite && oHit && (ofs == PRESC_OFS);

  // A software TL write in the overflow cycle discards that overflow entirely.
  assign overflow = tick && (tl == 32'hFFFF_FFFF) && !wrTl;

  timer_prescaler #(.PRESC_W(PRESC_W)) uPrescaler (
    .clk     (clk),
    .reset   (reset),
    .run     (state == RUNNING),
    .clear   (prescClear),
    .divisor (presc),
    .tick    (tick)
  );

  always_comb begin
    stateNext  = state;
    prescClear = wrPresc;
    case (state)
      STOPPED: begin
        if (wrTcon && iWData[TCON_EN]) begin
          stateNext  = RUNNING;
          prescClear = 1'b1;
        end
      end
      RUNNING: begin
        if (wrTcon) begin
          if (!iWData[TCON_EN]) stateNext = STOPPED;
        end else if (overflow && oneShot) begin
          stateNext = STOPPED;
        end
      end
    endcase
  end

  // TCON.EN is the FSM state itself, so a one-shot stop clears it on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STOPPED;
      th         <= '0;
      tl         <= '0;
      ie         <= 1'b0;
      pend       <= 1'b0;
      oneShot    <= 1'b0;
      presc      <= '0;
      oInterrupt <= 1'b0;
    end else begin
      state      <= stateNext;
      oInterrupt <= pend & ie;
      if (wrTh) th <= iWData;
      if (wrTl) begin
        tl <= iWData;
      end else if (tick) begin
        tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
      end
      if (wrTcon) begin
        ie      <= iWData[TCON_IE];
        oneShot <= iWData[TCON_ONESHOT];
      end
      if (overflow) begin
        pend <= 1'b1;
      end else if (wrTcon && iWData[TCON_PEND]) begin
        pend <= 1'b0;
      end
      if (wrPresc) presc <= iWData[PRESC_W-1:0];
    end
  end

`ifdef TIMER_SYSTICK_EN
  logic [31:0] sysTick;
  logic        wrSysTick;
  assign wrSysTick = iWrite && oHit && (ofs == SYSTICK_OFS);

  always_ff @(posedge clk) begin
    if (reset || wrSysTick) begin
      sysTick <= '0;
    end else begin
      sysTick <= sysTick + 32'd1;
    end
  end
`endif

  always_comb begin
    oRData = '0;
    if (iRead && oHit) begin
      case (ofs)
        TH_OFS:    oRData = th;
        TL_OFS:    oRData = tl;
        TCON_OFS:  oRData = {28'd0, oneShot, pend, ie, (state == RUNNING)};
        PRESC_OFS: oRData = 32'(presc);
`ifdef TIMER_SYSTICK_EN
        SYSTICK_OFS: oRData = sysTick;
`endif
        default:   oRData = '0;
      endcase
    end
  end

endmodule
